// File: rtl/student_iis_pkg.sv
// Shared types and defaults for the student I2S transmit/receive path.
// Contents: channel-FSM state enum, default sample/slot widths, L/R sample pair.
package student_iis_pkg;

    localparam int unsigned IIS_DATA_SIZE = 24;
    localparam int unsigned IIS_SLOT_BITS = 32;

    typedef enum logic [1:0] {
        SYNC,
        WAIT_MSB,
        SHIFT,
        PAD
    } iis_tx_state_e;

    typedef struct packed {
        logic [IIS_DATA_SIZE-1:0] left;
        logic [IIS_DATA_SIZE-1:0] right;
    } iis_sample_pair_t;

endpackage

// File: rtl/student_iis_shift_reg.sv
// Parallel-load shift register, MSB-first, zero fill on shift.
// Ports:
//   clk, rst (sync, active-high) ; load + din : parallel load (wins over shift)
//   shift : move one bit toward the MSB ; msb : current MSB
module student_iis_shift_reg
    import student_iis_pkg::*;
#(
    parameter int unsigned WIDTH = IIS_DATA_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/student_iis_tx.sv
// I2S serializer: accepts L/R sample pairs over valid/ready, shifts them out
// MSB-first on the DAC data line, framed by BCLK/LRCLK strobes from the clock gen.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   bclk_fall_i, lrclk_fall_i, lrclk_rise_i : one-cycle strobes from clock gen
//   sample_l_i, sample_r_i, sample_valid_i, sample_ready_o : sample handshake
//   sdata_o : serial DAC data ; underrun_o, frame_err_o : one-cycle status pulses
//   underrun_cnt_o : saturating underrun count
// Optional feature: define IIS_TX_UNDERRUN_CNT_EN to build the underrun counter;
// otherwise underrun_cnt_o is tied to zero.
module student_iis_tx
    import student_iis_pkg::*;
#(
    parameter int unsigned DATA_SIZE = IIS_DATA_SIZE,
    parameter int unsigned SLOT_BITS = IIS_SLOT_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bclk_fall_i,
    input  logic                 lrclk_fall_i,
    input  logic                 lrclk_rise_i,
    input  logic [DATA_SIZE-1:0] sample_l_i,
    input  logic [DATA_SIZE-1:0] sample_r_i,
    input  logic                 sample_valid_i,
    output logic                 sample_ready_o,
    output logic                 sdata_o,
    output logic                 underrun_o,
    output logic                 frame_err_o,
    output logic [15:0]          underrun_cnt_o
);

    localparam int unsigned CNT_W = $clog2(DATA_SIZE + 1);

    // The one-BCLK I2S delay needs at least one slot left over after the data.
    if (DATA_SIZE > SLOT_BITS - 1) begin : g_cfg_check
        $error("student_iis_tx: DATA_SIZE must be at most SLOT_BITS-1");
    end

    iis_tx_state_e        state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [DATA_SIZE-1:0] hold_l, hold_r, active_r;
    logic                 hold_empty;
    logic                 sdata, sdata_d;
    logic                 underrun, underrun_d;
    logic                 frame_err, frame_err_d;
    logic                 xfer, ch_start, short_ch;
    logic [DATA_SIZE-1:0] next_l, next_r;
    logic                 sr_load, sr_shift, sr_msb;
    logic [DATA_SIZE-1:0] sr_din;

    student_iis_shift_reg #(.WIDTH(DATA_SIZE)) u_shift (
        .clk   (clk_i),
        .rst   (rst_i),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (sr_din),
        .msb   (sr_msb)
    );

    // Frame-start source: held pair first, then same-cycle bypass, else silence.
    always_comb begin
        xfer       = sample_valid_i && hold_empty;
        next_l     = !hold_empty ? hold_l : (xfer ? sample_l_i : '0);
        next_r     = !hold_empty ? hold_r : (xfer ? sample_r_i : '0);
        underrun_d = lrclk_fall_i && hold_empty && !xfer;
    end

    // Channel FSM: LRCLK strobes restart a channel and override the coincident BCLK slot.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        sdata_d     = sdata;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_din      = next_l;
        frame_err_d = 1'b0;
        ch_start    = lrclk_fall_i || (lrclk_rise_i && (state != SYNC));
        short_ch    = (state == WAIT_MSB) || ((state == SHIFT) && (cnt < CNT_W'(DATA_SIZE)));

        if (ch_start) begin
            frame_err_d = short_ch;
            sr_load     = 1'b1;
            sr_din      = lrclk_fall_i ? next_l : active_r;
            state_d     = WAIT_MSB;
            cnt_d       = '0;
            // The slot under the LRCLK edge is the delay slot; a truncated channel is cut here.
            if (bclk_fall_i) begin
                sdata_d = 1'b0;
            end
        end else if (bclk_fall_i) begin
            case (state)
                SYNC: begin
                    sdata_d = 1'b0;
                end
                WAIT_MSB: begin
                    sdata_d  = sr_msb;
                    sr_shift = 1'b1;
                    cnt_d    = CNT_W'(1);
                    state_d  = SHIFT;
                end
                SHIFT: begin
                    if (cnt < CNT_W'(DATA_SIZE)) begin
                        sdata_d  = sr_msb;
                        sr_shift = 1'b1;
                        cnt_d    = cnt + CNT_W'(1);
                    end else begin
                        sdata_d = 1'b0;
                        state_d = PAD;
                    end
                end
                PAD: begin
                    sdata_d = 1'b0;
                end
                default: begin
                    sdata_d = 1'b0;
                    state_d = SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= SYNC;
            cnt        <= '0;
            sdata      <= 1'b0;
            underrun   <= 1'b0;
            frame_err  <= 1'b0;
            hold_empty <= 1'b1;
            hold_l     <= '0;
            hold_r     <= '0;
            active_r   <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sdata     <= sdata_d;
            underrun  <= underrun_d;
            frame_err <= frame_err_d;
            if (lrclk_fall_i) begin
                // Held pair (or bypassed input) becomes active; hold is empty afterwards.
                active_r   <= next_r;
                hold_empty <= 1'b1;
            end else if (xfer) begin
                hold_l     <= sample_l_i;
                hold_r     <= sample_r_i;
                hold_empty <= 1'b0;
            end
        end
    end

`ifdef IIS_TX_UNDERRUN_CNT_EN
    logic [15:0] ur_cnt;

    // Saturating count of frames started without data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ur_cnt <= '0;
        end else if (underrun_d && (ur_cnt != 16'hFFFF)) begin
            ur_cnt <= ur_cnt + 16'd1;
        end
    end

    assign underrun_cnt_o = ur_cnt;
`else
    assign underrun_cnt_o = '0;
`endif

    assign sample_ready_o = hold_empty;
    assign sdata_o        = sdata;
    assign underrun_o     = underrun;
    assign frame_err_o    = frame_err;

endmodule
